// File: rtl/seg7_display_sched.sv
// seg7_display_sched: shares the four BCD digit outputs between the live score
// and a temporarily held message value. Binary values are converted with a
// 10-step double-dabble engine, and all four digits change on a single edge.
module seg7_display_sched #(
   parameter int HOLD_CYCLES    = 200_000_000,
   parameter int REFRESH_CYCLES = 1_000_000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic [9:0] score,
   input  logic       msg_req,
   input  logic [9:0] msg_value,
   output logic       msg_ack,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic [3:0] thousands,
   output logic       showing_msg,
   output logic       busy
);

   localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   ref_q, ref_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            pend_q, pend_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [9:0]      sh_q, sh_d;
   logic [15:0]     bcd_q, bcd_d;
   logic            src_q, src_d;     // 1: message, 0: score
   logic [15:0]     dig_q, dig_d;     // {thousands, hundreds, tens, ones}
   logic            show_q, show_d;
   logic            busy_q, busy_d;
   logic            ack_q, ack_d;

   logic            ref_tc;
   logic            hold_expire;
   logic            hold_active;
   logic [15:0]     bcd_adj;

   // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Timers, arbitration and conversion sequencing.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      bcd_d       = bcd_q;
      src_d       = src_q;
      dig_d       = dig_q;
      show_d      = show_q;
      busy_d      = busy_q;
      ack_d       = 1'b0;

      // Free-running refresh timer.
      ref_tc = (ref_q == RW'(REFRESH_CYCLES - 1));
      ref_d  = ref_tc ? '0 : ref_q + RW'(1);

      // Hold timer runs down only while a message is on display and stops at 0.
      hold_active = (hold_q != '0);
      hold_d      = hold_q;
      hold_expire = 1'b0;
      if (show_q && hold_active) begin
         hold_d      = hold_q - HW'(1);
         hold_expire = (hold_q == HW'(1));
      end

      case (state_q)
         IDLE: begin
            if (msg_req) begin
               ack_d   = 1'b1;
               sh_d    = msg_value;
               src_d   = 1'b1;
               pend_d  = 1'b0;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CONVERT;
            end else if (pend_q && !hold_active) begin
               sh_d    = score;
               src_d   = 1'b0;
               pend_d  = 1'b0;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CONVERT;
            end else if (pend_q) begin
               // Score refresh is suppressed while a message is held.
               pend_d = 1'b0;
            end
         end
         CONVERT: begin
            bcd_d = {bcd_adj[14:0], sh_q[9]};
            sh_d  = {sh_q[8:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9)
               state_d = COMMIT;
         end
         COMMIT: begin
            dig_d   = bcd_q;
            show_d  = src_q;
            if (src_q)
               hold_d = HW'(HOLD_CYCLES);
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A new request event wins over a same-cycle clear so none is lost.
      if (ref_tc || hold_expire)
         pend_d = 1'b1;
   end

   // State register; reset puts the score up immediately after release.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ref_q   <= '0;
         hold_q  <= '0;
         pend_q  <= 1'b1;
         cnt_q   <= '0;
         sh_q    <= '0;
         bcd_q   <= '0;
         src_q   <= 1'b0;
         dig_q   <= '0;
         show_q  <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         src_q   <= src_d;
         dig_q   <= dig_d;
         show_q  <= show_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign thousands   = dig_q[15:12];
   assign hundreds    = dig_q[11:8];
   assign tens        = dig_q[7:4];
   assign ones        = dig_q[3:0];
   assign showing_msg = show_q;
   assign busy        = busy_q;
   assign msg_ack     = ack_q;

endmodule

// File: tb/tb_seg7_display_sched.sv
// Bench for seg7_display_sched: a timeline model predicts each conversion
// (start edge, value, source); a negedge monitor checks every commit against
// the scoreboard plus busy/ack activity cycle by cycle.
module tb_seg7_display_sched;

   localparam int HOLD    = 50;
   localparam int REFRESH = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] score;
   logic       msg_req;
   logic [9:0] msg_value;
   logic       msg_ack;
   logic [3:0] ones, tens, hundreds, thousands;
   logic       showing_msg;
   logic       busy;
   logic [15:0] dig;

   assign dig = {thousands, hundreds, tens, ones};

   seg7_display_sched #(.HOLD_CYCLES(HOLD), .REFRESH_CYCLES(REFRESH)) dut (
      .clk_100MHz (clk),
      .reset      (reset),
      .score      (score),
      .msg_req    (msg_req),
      .msg_value  (msg_value),
      .msg_ack    (msg_ack),
      .ones       (ones),
      .tens       (tens),
      .hundreds   (hundreds),
      .thousands  (thousands),
      .showing_msg(showing_msg),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int bcd(input int v);
      return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   typedef struct {
      int val;
      bit msg;
      int edge_n;
   } exp_t;

   // ---------------- reference model (edge timeline) ----------------
   int   n      = 0;        // edges since reset release
   int   s_last = -100;     // edge of the latest conversion start
   int   mc     = -100000;  // edge of the latest message commit
   bit   m_pend = 1'b1;
   bit   last_msg = 1'b0;
   bit   exp_ack  = 1'b0;
   bit   idle, hact, setp;
   exp_t sbq[$];

   task automatic start_conv(input int v, input bit m);
      exp_t e;
      e.val = v; e.msg = m; e.edge_n = n + 11;
      s_last = n;
      last_msg = m;
      sbq.push_back(e);
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         n = 0; s_last = -100; mc = -100000;
         m_pend = 1'b1; last_msg = 1'b0; exp_ack = 1'b0;
         sbq.delete();
      end else begin
         n++;
         idle = (n > s_last + 11);
         hact = (n > mc) && (n <= mc + HOLD);
         setp = (n % REFRESH == 0) || (n == mc + HOLD);
         exp_ack = 1'b0;
         if (n == s_last + 11 && last_msg) mc = n;
         if (idle) begin
            if (msg_req) begin
               start_conv(int'(msg_value), 1'b1);
               exp_ack = 1'b1;
            end else if (m_pend && !hact) begin
               start_conv(int'(score), 1'b0);
            end
            m_pend = 1'b0;
         end
         if (setp) m_pend = 1'b1;
      end
   end

   // ---------------- monitor ----------------
   bit prev_busy = 1'b0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
         prev_busy = 1'b0;
      end else begin
         chk("busy", int'(busy), int'(n >= s_last && n <= s_last + 10));
         if (msg_ack || exp_ack) chk("msg_ack", int'(msg_ack), int'(exp_ack));
         if (prev_busy && !busy) begin
            if (sbq.size() == 0) begin
               chk("commit_unexpected", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("commit_digits", int'(dig), bcd(e.val));
               chk("commit_showing_msg", int'(showing_msg), int'(e.msg));
               chk("commit_edge", n, e.edge_n);
            end
            chk("digit_range", int'(ones <= 9 && tens <= 9 && hundreds <= 9 && thousands <= 9), 1);
         end
         prev_busy = busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_msg(input logic [9:0] v, output int lat);
      int k;
      msg_value = v;
      msg_req   = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!msg_ack && k < 300);
      if (!msg_ack) chk("ack_timeout", 0, 1);
      msg_req = 1'b0;
      lat = k;
   endtask

   task automatic wait_busy_rise();
      int k;
      k = 0;
      while (!busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!busy) chk("busy_timeout", 0, 1);
   endtask

   task automatic wait_show_fall();
      int k;
      k = 0;
      while (showing_msg && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (showing_msg) chk("hold_timeout", 1, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int r;
      int v;
      reset = 1'b1; score = '0; msg_req = 1'b0; msg_value = '0;
      repeat (3) @(negedge clk);
      chk("reset_digits", int'(dig), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ack", int'(msg_ack), 0);

      // 1: score shown right after reset release
      score = 10'd937;
      reset = 1'b0;
      repeat (14) @(negedge clk);
      chk("t1_digits", int'(dig), bcd(937));
      chk("t1_showing", int'(showing_msg), 0);
      chk("t1_busy", int'(busy), 0);

      // 2: extremes
      score = 10'd1023;
      repeat (25) @(negedge clk);
      chk("t2_max", int'(dig), bcd(1023));
      score = 10'd0;
      repeat (20) @(negedge clk);
      chk("t2_zero", int'(dig), 0);

      // 3: message hold then score returns
      score = 10'd500;
      repeat (20) @(negedge clk);
      send_msg(10'd42, lat);
      repeat (11) @(negedge clk);
      chk("t3_msg_digits", int'(dig), bcd(42));
      chk("t3_msg_showing", int'(showing_msg), 1);
      score = 10'd600;
      repeat (30) @(negedge clk);
      chk("t3_hold_digits", int'(dig), bcd(42));
      wait_show_fall();
      chk("t3_score_after_hold", int'(dig), bcd(600));

      // 4: request on the refresh terminal-count cycle
      lat = 0;
      while (n % REFRESH != REFRESH - 1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      v = int'($urandom_range(0, 1023));
      send_msg(10'(v), lat);
      chk("t4_ack_latency", lat, 1);
      repeat (11) @(negedge clk);
      chk("t4_msg_digits", int'(dig), bcd(v));
      repeat (30) @(negedge clk);
      chk("t4_hold_digits", int'(dig), bcd(v));

      // 5: request raised while busy waits for IDLE
      wait_busy_rise();
      v = int'($urandom_range(0, 1023));
      send_msg(10'(v), lat);
      chk("t5_ack_latency", lat, 12);
      repeat (11) @(negedge clk);
      chk("t5_msg_digits", int'(dig), bcd(v));
      chk("t5_msg_showing", int'(showing_msg), 1);

      // 6: reset in the middle of a conversion
      wait_show_fall();
      score = 10'd999;
      @(negedge clk);
      wait_busy_rise();
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t6_reset_digits", int'(dig), 0);
      chk("t6_reset_busy", int'(busy), 0);
      chk("t6_reset_showing", int'(showing_msg), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (14) @(negedge clk);
      chk("t6_after_reset", int'(dig), bcd(999));

      // randomized traffic
      for (int i = 0; i < 50; i++) begin
         r = int'($urandom_range(0, 3));
         if (r == 0) send_msg(10'($urandom_range(0, 1023)), lat);
         else score = 10'($urandom_range(0, 1023));
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end
      repeat (150) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
